// File: rtl/instruction_memory_sync_if.sv
// Fetch/load bus of the synchronous instruction memory.
// The IMEM_PARITY_EN macro adds the ParityErr response signal.
interface instruction_memory_sync_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 64
);
   logic                  ReqValid;
   logic [ADDR_WIDTH-1:0] Address;
   logic                  Hold;
   logic [DATA_WIDTH-1:0] Data;
   logic                  DataValid;
   logic                  FetchErr;
   logic                  LoadEn;
   logic [ADDR_WIDTH-1:0] LoadAddr;
   logic [DATA_WIDTH-1:0] LoadData;
   logic                  LoadErr;
`ifdef IMEM_PARITY_EN
   logic                  ParityErr;

   modport master (
      output ReqValid, Address, Hold, LoadEn, LoadAddr, LoadData,
      input  Data, DataValid, FetchErr, LoadErr, ParityErr
   );
   modport slave (
      input  ReqValid, Address, Hold, LoadEn, LoadAddr, LoadData,
      output Data, DataValid, FetchErr, LoadErr, ParityErr
   );
`else
   modport master (
      output ReqValid, Address, Hold, LoadEn, LoadAddr, LoadData,
      input  Data, DataValid, FetchErr, LoadErr
   );
   modport slave (
      input  ReqValid, Address, Hold, LoadEn, LoadAddr, LoadData,
      output Data, DataValid, FetchErr, LoadErr
   );
`endif
endinterface

// File: rtl/instruction_memory_sync.sv
// Synchronous instruction memory: word-aligned fetch port with 1 or 2 cycles of read
// latency and a stall input, plus a run-time program-load write port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag corrupt fetches.
module instruction_memory_sync #(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           ADDR_WIDTH   = 64,
   parameter int unsigned           DEPTH        = 256,
   parameter int unsigned           READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 32'hD503201F
) (
   input logic                      CLK,
   input logic                      Reset,
   instruction_memory_sync_if.slave bus
);
   localparam int unsigned IdxW = $clog2(DEPTH);

   // Program storage; deliberately not reset so a reset keeps the loaded program.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef IMEM_PARITY_EN
   logic                  par_q [DEPTH];
`endif

   logic [IdxW-1:0]       fetch_idx;
   logic [IdxW-1:0]       load_idx;
   logic                  fetch_bad;
   logic                  load_bad;
   logic [DATA_WIDTH-1:0] fetch_word;
   logic                  fetch_par_err;

   // Stage-1 registers hold the array read result.
   logic                  s1_valid_d, s1_valid_q;
   logic [DATA_WIDTH-1:0] s1_data_d,  s1_data_q;
   logic                  s1_ferr_d,  s1_ferr_q;
   logic                  s1_perr_d,  s1_perr_q;
   logic                  load_err_d, load_err_q;

   // Address decode: index, misalignment and any set bit above the array range.
   always_comb begin
      fetch_idx = bus.Address[IdxW+1:2];
      load_idx  = bus.LoadAddr[IdxW+1:2];
      fetch_bad = (bus.Address[1:0] != 2'b00) || ((bus.Address >> (IdxW + 2)) != '0);
      load_bad  = (bus.LoadAddr[1:0] != 2'b00) || ((bus.LoadAddr >> (IdxW + 2)) != '0);
      fetch_word = fetch_bad ? DEFAULT_WORD : mem_q[fetch_idx];
`ifdef IMEM_PARITY_EN
      // Bad addresses return the default word and never report parity.
      fetch_par_err = !fetch_bad && ((^mem_q[fetch_idx]) != par_q[fetch_idx]);
`else
      fetch_par_err = 1'b0;
`endif
   end

   // Array write; nonblocking update gives read-before-write for a same-cycle fetch.
   always_ff @(posedge CLK) begin
      if (bus.LoadEn && !load_bad) begin
         mem_q[load_idx] <= bus.LoadData;
`ifdef IMEM_PARITY_EN
         par_q[load_idx] <= ^bus.LoadData;
`endif
      end
   end

   // Stage-1 next state: frozen under Hold; Data only changes on a real request.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_ferr_d  = s1_ferr_q;
      s1_perr_d  = s1_perr_q;
      if (!bus.Hold) begin
         s1_valid_d = bus.ReqValid;
         s1_ferr_d  = bus.ReqValid && fetch_bad;
         s1_perr_d  = bus.ReqValid && fetch_par_err;
         if (bus.ReqValid) begin
            s1_data_d = fetch_word;
         end
      end
      load_err_d = bus.LoadEn && load_bad;
   end

   // Stage-1 and load-error registers.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_ferr_q  <= 1'b0;
         s1_perr_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_ferr_q  <= s1_ferr_d;
         s1_perr_q  <= s1_perr_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.LoadErr = load_err_q;

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q;
      logic [DATA_WIDTH-1:0] s2_data_q;
      logic                  s2_ferr_q;
      logic                  s2_perr_q;

      // Output register stage; advances with stage 1 and keeps Data across bubbles.
      always_ff @(posedge CLK or posedge Reset) begin
         if (Reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ferr_q  <= 1'b0;
            s2_perr_q  <= 1'b0;
         end else if (!bus.Hold) begin
            s2_valid_q <= s1_valid_q;
            s2_ferr_q  <= s1_ferr_q;
            s2_perr_q  <= s1_perr_q;
            if (s1_valid_q) begin
               s2_data_q <= s1_data_q;
            end
         end
      end

      assign bus.Data      = s2_data_q;
      assign bus.DataValid = s2_valid_q;
      assign bus.FetchErr  = s2_ferr_q;
`ifdef IMEM_PARITY_EN
      assign bus.ParityErr = s2_perr_q;
`endif
   end else begin : g_lat1
      assign bus.Data      = s1_data_q;
      assign bus.DataValid = s1_valid_q;
      assign bus.FetchErr  = s1_ferr_q;
`ifdef IMEM_PARITY_EN
      assign bus.ParityErr = s1_perr_q;
`endif
   end

endmodule
